// File: rtl/cigar_rle.sv
`default_nettype none
// ============================================================================
//  Module   : cigar_rle
//  Purpose  : Run-length encodes a reverse-ordered compact traceback CIGAR
//             vector into (op, len, last) runs over a valid/ready stream.
//  Revision : 1.0
// ============================================================================
module cigar_rle #(
    parameter int MAX_WAVEFRONT_LEN     = 256,
    parameter int LOG_MAX_WAVEFRONT_LEN = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [2*MAX_WAVEFRONT_LEN-1:0]     cigar_flat,
    input  logic [LOG_MAX_WAVEFRONT_LEN-1:0]   num_compact,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [1:0]                         out_op,
    output logic [LOG_MAX_WAVEFRONT_LEN:0]     out_len,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done
);

    localparam int LW = LOG_MAX_WAVEFRONT_LEN;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SCAN   = 2'd1;
    localparam logic [1:0] c_EMIT   = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    localparam logic [1:0]    c_OP_SKIP = 2'b11;
    localparam logic [LW-1:0] c_ONE_IDX = 1;
    localparam logic [LW:0]   c_ONE_LEN = 1;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [LW-1:0] r_idx;
    logic [LW-1:0] r_remaining;
    logic [LW:0]   r_run_len;
    logic [1:0]    r_run_op;
    logic          r_last;

    logic [1:0]    w_op;
    logic          w_skip;
    logic          w_break;
    logic          w_final;
    logic [LW:0]   w_run_len_next;

    assign w_op    = cigar_flat[{r_idx, 1'b0} +: 2];
    assign w_skip  = (w_op == c_OP_SKIP);
    // A break leaves the current entry unconsumed so it seeds the next run.
    assign w_break = !w_skip && (r_run_len != '0) && (w_op != r_run_op);
    assign w_final = (r_remaining == c_ONE_IDX);
    assign w_run_len_next = w_skip ? r_run_len : (r_run_len + c_ONE_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = (num_compact == '0) ? c_FINISH : c_SCAN;
                end
            end
            c_SCAN: begin
                if (w_break) begin
                    w_next_state = c_EMIT;
                end else if (w_final) begin
                    w_next_state = (w_run_len_next != '0) ? c_EMIT : c_FINISH;
                end
            end
            c_EMIT: begin
                if (out_ready) begin
                    w_next_state = r_last ? c_FINISH : c_SCAN;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_remaining <= '0;
            r_run_len   <= '0;
            r_run_op    <= '0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_idx       <= num_compact - c_ONE_IDX;
                        r_remaining <= num_compact;
                        r_run_len   <= '0;
                        r_last      <= 1'b0;
                    end
                end
                c_SCAN: begin
                    if (w_break) begin
                        r_last <= 1'b0;
                    end else begin
                        r_idx       <= r_idx - c_ONE_IDX;
                        r_remaining <= r_remaining - c_ONE_IDX;
                        r_run_len   <= w_run_len_next;
                        r_last      <= w_final;
                        if (!w_skip) begin
                            r_run_op <= w_op;
                        end
                    end
                end
                c_EMIT: begin
                    if (out_ready) begin
                        r_run_len <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (r_state == c_EMIT);
        out_op    = (r_state == c_EMIT) ? r_run_op : 2'b00;
        out_len   = (r_state == c_EMIT) ? r_run_len : '0;
        out_last  = (r_state == c_EMIT) && r_last;
        busy      = (r_state != c_IDLE);
        done      = (r_state == c_FINISH);
    end

endmodule
`default_nettype wire

// File: doc/cigar_rle.md
CIGAR_RLE -- requirements
Module: cigar_rle

Interface
REQ-001 Parameter MAX_WAVEFRONT_LEN, default 256: number of compact CIGAR entries.
REQ-002 Parameter LOG_MAX_WAVEFRONT_LEN, default 8: index and count width.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse meaning traceback finished and the cigar vector is valid.
REQ-006 cigar_flat  input  2*MAX_WAVEFRONT_LEN  packed traceback ops; entry i = bits [2i+1:2i].
REQ-007 num_compact  input  LOG_MAX_WAVEFRONT_LEN  count of valid entries, indices 0..num_compact-1.
REQ-008 out_valid  output  1  a run is presented.
REQ-009 out_ready  input  1  consumer accepts the run.
REQ-010 out_op  output  2  run opcode: 00 match, 01 insertion, 10 deletion.
REQ-011 out_len  output  LOG_MAX_WAVEFRONT_LEN+1  run length, at least 1.
REQ-012 out_last  output  1  the presented run is the final run of the alignment.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the conversion ends.

Function
REQ-015 The block SHALL read entries in forward alignment order, from index num_compact-1 down to index 0, because traceback writes them in reverse.
REQ-016 Entries with value 11 SHALL be skipped and SHALL NOT count toward any run.
REQ-017 FSM states SHALL be IDLE, SCAN, EMIT and FINISH.
REQ-018 IDLE: start=1 latches num_compact; idx=num_compact-1, remaining=num_compact, run_len=0.
  - Next state is SCAN, or FINISH when num_compact=0.
  - start SHALL be ignored in all states other than IDLE.
REQ-019 SCAN consumes exactly one entry per cycle, taking op = cigar[idx]:
  - op=11: skip the entry.
  - run_len=0: run_op=op, run_len=1.
  - op=run_op: run_len+1.
  - op differs from run_op: go to EMIT with out_last=0; the entry is NOT consumed and idx and remaining are unchanged.
  - Every consumed entry SHALL decrement idx and remaining.
REQ-020 When SCAN consumes the final entry (remaining=1) without a break:
  - Go to EMIT with out_last=1 if the resulting run_len>0.
  - Otherwise go to FINISH.
REQ-021 EMIT holds out_valid=1 with out_op=run_op, out_len=run_len and out_last.
  - All outputs SHALL stay stable until out_ready=1.
  - out_valid SHALL NOT drop without a handshake.
REQ-022 On the EMIT handshake (out_valid and out_ready in the same cycle): run_len=0.
  - out_last=1: next state FINISH.
  - out_last=0: next state SCAN.
REQ-023 FINISH SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-024 cigar_flat and num_compact SHALL be held stable by the upstream stage while busy=1; the block does not copy the vector.
REQ-025 Latency: for N entries forming R runs with no backpressure, the first out_valid SHALL rise within N+1 cycles of start.
  - Each run break SHALL cost one extra cycle.
REQ-026 out_len SHALL never wrap; a maximum run of MAX_WAVEFRONT_LEN-1 entries SHALL be reported exactly.
REQ-027 Adjacent runs emitted by the block SHALL never share the same opcode.

Reset
REQ-028 rst=1 SHALL force IDLE in the same clock edge, including mid-SCAN and mid-EMIT.
REQ-029 Reset values SHALL be: out_valid=0, out_op=0, out_len=0, out_last=0, busy=0, done=0, idx=0, remaining=0, run_len=0.
REQ-030 A start that coincides with rst=1 SHALL be ignored.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
  - num_compact=3, entries [00,00,00], out_ready=1, start at cycle t -> out_valid at t+4 with op=00, len=3, last=1; done at t+5.
  - num_compact=4, entries idx3..0 = 01,00,00,10 -> runs (01,1,last=0), (00,2,last=0), (10,1,last=1).
  - num_compact=4, entries idx3..0 = 11,00,11,00 -> a single run (00,2,last=1).
  - num_compact=0 -> no out_valid; done at t+1.
  - num_compact=2, all 11 -> no out_valid; done pulse.
  - out_ready held 0 for 5 cycles during EMIT of (01,1) -> out_valid and all outputs stable for 5 cycles; run accepted on the 6th.
  - rst asserted mid-SCAN -> next cycle busy=0 and out_valid=0; a following start with num_compact=1, entry 10 -> (10,1,last=1).
  - A start pulse while busy=1 -> ignored; the run stream is identical to the same test without the extra pulse.
